mem_wb_sequencer: RTL and testbench

Multicycle memory-access and writeback sequencer for the 32-bit MIPS datapath. It accepts one executed instruction at a time from the execute stage and issues any load or store to a variable-latency data memory. It then drives the writeback select (MemtoReg), the register-file write enable and the destination register for the writeback mux and register file. It also carries a bounded memory-wait timeout with a sticky error flag.

---
 rtl/mem_wb_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mem_wb_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_sequencer.sv
// Memory-access / writeback sequencer for the multicycle MIPS datapath.
// Takes one executed instruction at a time, runs any load/store against a
// variable-latency data memory with a bounded wait, then issues a single
// writeback strobe. Every output is a register.
module mem_wb_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ExValid,
    output logic        o_ExReady,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic        i_RegWriteIn,
    input  logic [4:0]  i_WriteRegIn,
    input  logic [31:0] i_ALUOut,
    input  logic [31:0] i_StoreData,
    output logic        o_MemReq,
    output logic        o_MemWe,
    output logic [31:0] o_MemAddr,
    output logic [31:0] o_MemWData,
    input  logic        i_MemAck,
    input  logic [31:0] i_MemRData,
    output logic        o_MemtoReg,
    output logic        o_RegWrite,
    output logic [4:0]  o_WriteReg,
    output logic [31:0] o_ReadDataReg,
    output logic [31:0] o_ALUOutReg,
    output logic        o_MemErr
);

    // Last wait-count value allowed before the access is abandoned.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Instruction fields captured at accept.
    logic        r_mr;
    logic        r_mw;
    logic        r_rw;
    logic [4:0]  r_wr;
    logic [7:0]  r_wait_cnt;

    // Registered outputs.
    logic        r_ex_ready;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_to_reg;
    logic        r_reg_write;
    logic [4:0]  r_write_reg;
    logic [31:0] r_read_data;
    logic [31:0] r_alu_out;
    logic        r_mem_err;

    logic        w_accept;
    logic        w_ack;
    logic        w_timeout;
    logic        w_illegal;

    // Next values of the registered outputs.
    logic        w_ex_ready_d;
    logic        w_mem_req_d;
    logic        w_mem_we_d;
    logic        w_mem_to_reg_d;
    logic        w_reg_write_d;
    logic [4:0]  w_write_reg_d;
    logic [31:0] w_read_data_d;
    logic        w_mem_err_d;
    logic [7:0]  w_wait_cnt_d;

    assign w_accept  = (r_state == S_IDLE) & i_ExValid & r_ex_ready;
    assign w_ack     = (r_state == S_MEM) & i_MemAck;
    assign w_timeout = (r_state == S_MEM) & ~i_MemAck & (r_wait_cnt == LIMIT);
    assign w_illegal = w_accept & i_MemRead & i_MemWrite;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic; a timeout leaves MEM just like an ack does.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (i_MemRead ^ i_MemWrite) ? S_MEM : S_WB;
            S_MEM:  if (w_ack || w_timeout) w_next = S_WB;
            S_WB:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: derives next register values from the upcoming state,
    // using live inputs on the IDLE->WB path since nothing is latched yet.
    always_comb begin
        w_ex_ready_d   = (w_next == S_IDLE);
        w_mem_req_d    = (w_next == S_MEM);
        w_mem_we_d     = 1'b0;
        w_mem_to_reg_d = r_mem_to_reg;
        w_reg_write_d  = 1'b0;
        w_write_reg_d  = r_write_reg;
        w_read_data_d  = r_read_data;
        w_mem_err_d    = r_mem_err | w_illegal | w_timeout;
        w_wait_cnt_d   = 8'd0;
        if (w_next == S_MEM) begin
            w_mem_we_d = (r_state == S_IDLE) ? i_MemWrite : r_mw;
            if (r_state == S_MEM) w_wait_cnt_d = r_wait_cnt + 8'd1;
        end
        if (w_ack && r_mr) w_read_data_d = i_MemRData;
        if (w_next == S_WB) begin
            if (r_state == S_IDLE) begin
                w_reg_write_d  = i_RegWriteIn & ~i_MemWrite & ~w_illegal;
                w_mem_to_reg_d = i_MemRead;
                w_write_reg_d  = i_WriteRegIn;
            end else begin
                w_reg_write_d  = r_rw & ~r_mw & ~w_timeout;
                w_mem_to_reg_d = r_mr;
                w_write_reg_d  = r_wr;
            end
        end
    end

    // Output and datapath registers; instruction fields load on accept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ex_ready   <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_read_data  <= '0;
            r_alu_out    <= '0;
            r_mem_err    <= 1'b0;
            r_wait_cnt   <= '0;
            r_mr         <= 1'b0;
            r_mw         <= 1'b0;
            r_rw         <= 1'b0;
            r_wr         <= '0;
        end else begin
            r_ex_ready   <= w_ex_ready_d;
            r_mem_req    <= w_mem_req_d;
            r_mem_we     <= w_mem_we_d;
            r_mem_to_reg <= w_mem_to_reg_d;
            r_reg_write  <= w_reg_write_d;
            r_write_reg  <= w_write_reg_d;
            r_read_data  <= w_read_data_d;
            r_mem_err    <= w_mem_err_d;
            r_wait_cnt   <= w_wait_cnt_d;
            if (w_accept) begin
                r_mr        <= i_MemRead;
                r_mw        <= i_MemWrite;
                r_rw        <= i_RegWriteIn;
                r_wr        <= i_WriteRegIn;
                r_mem_addr  <= i_ALUOut;
                r_mem_wdata <= i_StoreData;
                r_alu_out   <= i_ALUOut;
            end
        end
    end

    assign o_ExReady     = r_ex_ready;
    assign o_MemReq      = r_mem_req;
    assign o_MemWe       = r_mem_we;
    assign o_MemAddr     = r_mem_addr;
    assign o_MemWData    = r_mem_wdata;
    assign o_MemtoReg    = r_mem_to_reg;
    assign o_RegWrite    = r_reg_write;
    assign o_WriteReg    = r_write_reg;
    assign o_ReadDataReg = r_read_data;
    assign o_ALUOutReg   = r_alu_out;
    assign o_MemErr      = r_mem_err;

endmodule

// File: tb/tb_mem_wb_sequencer.sv
// Bench for mem_wb_sequencer: directed cases then randomized transactions,
// each checked against a transaction-level model of the expected timeline.
module tb_mem_wb_sequencer;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        ExValid, MemRead, MemWrite, RegWriteIn, MemAck;
    logic [4:0]  WriteRegIn;
    logic [31:0] ALUOut, StoreData, MemRData;
    logic        o_ExReady, o_MemReq, o_MemWe, o_MemtoReg, o_RegWrite, o_MemErr;
    logic [4:0]  o_WriteReg;
    logic [31:0] o_MemAddr, o_MemWData, o_ReadDataReg, o_ALUOutReg;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural expectations carried across transactions.
    logic        exp_err = 1'b0;
    logic        exp_m2r = 1'b0;
    logic [4:0]  exp_wr  = '0;
    logic [31:0] exp_rd  = '0;
    logic [31:0] exp_alu = '0;

    always #5 clk = ~clk;

    mem_wb_sequencer #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(reset), .i_ExValid(ExValid), .o_ExReady(o_ExReady),
        .i_MemRead(MemRead), .i_MemWrite(MemWrite), .i_RegWriteIn(RegWriteIn),
        .i_WriteRegIn(WriteRegIn), .i_ALUOut(ALUOut), .i_StoreData(StoreData),
        .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr),
        .o_MemWData(o_MemWData), .i_MemAck(MemAck), .i_MemRData(MemRData),
        .o_MemtoReg(o_MemtoReg), .o_RegWrite(o_RegWrite), .o_WriteReg(o_WriteReg),
        .o_ReadDataReg(o_ReadDataReg), .o_ALUOutReg(o_ALUOutReg), .o_MemErr(o_MemErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(o_ExReady), 32'd1);
        chk({tag, "_req"},   32'(o_MemReq), 32'd0);
        chk({tag, "_we"},    32'(o_MemWe), 32'd0);
        chk({tag, "_addr"},  o_MemAddr, 32'd0);
        chk({tag, "_wdata"}, o_MemWData, 32'd0);
        chk({tag, "_m2r"},   32'(o_MemtoReg), 32'd0);
        chk({tag, "_rw"},    32'(o_RegWrite), 32'd0);
        chk({tag, "_wr"},    32'(o_WriteReg), 32'd0);
        chk({tag, "_rd"},    o_ReadDataReg, 32'd0);
        chk({tag, "_alu"},   o_ALUOutReg, 32'd0);
        chk({tag, "_err"},   32'(o_MemErr), 32'd0);
    endtask

    // One instruction, entered at the falling edge of an IDLE cycle.
    // k = MEM cycle on which the ack arrives; k outside 1..TO means no ack.
    task automatic do_op(input logic mr, input logic mw, input logic rw,
                         input logic [4:0] wr, input logic [31:0] alu,
                         input logic [31:0] sd, input int k,
                         input logic [31:0] rdata, input bit hold);
        bit is_mem, illegal, tmo;
        int nm;
        illegal = mr & mw;
        is_mem  = mr ^ mw;
        tmo     = is_mem && !(k >= 1 && k <= TO);
        nm      = !is_mem ? 0 : (tmo ? TO : k);
        chk("idle_ready", 32'(o_ExReady), 32'd1);
        chk("idle_req", 32'(o_MemReq), 32'd0);
        ExValid = 1'b1; MemRead = mr; MemWrite = mw; RegWriteIn = rw;
        WriteRegIn = wr; ALUOut = alu; StoreData = sd;
        MemAck = 1'($urandom); MemRData = $urandom;
        @(negedge clk);
        if (!hold) ExValid = 1'b0;
        for (int i = 0; i < nm; i++) begin
            chk("mem_req", 32'(o_MemReq), 32'd1);
            chk("mem_we", 32'(o_MemWe), 32'(mw));
            chk("mem_addr", o_MemAddr, alu);
            chk("mem_wdata", o_MemWData, sd);
            chk("mem_ready", 32'(o_ExReady), 32'd0);
            chk("mem_rw", 32'(o_RegWrite), 32'd0);
            MemAck   = (i == nm - 1) && !tmo;
            MemRData = MemAck ? rdata : $urandom;
            @(negedge clk);
        end
        // Writeback cycle; a stray ack here must be ignored.
        MemAck = 1'($urandom);
        MemRData = $urandom;
        if (illegal || tmo) exp_err = 1'b1;
        if (mr && is_mem && !tmo) exp_rd = rdata;
        exp_m2r = mr; exp_wr = wr; exp_alu = alu;
        chk("wb_rw", 32'(o_RegWrite), 32'(rw & !mw & !(illegal | tmo)));
        chk("wb_m2r", 32'(o_MemtoReg), 32'(exp_m2r));
        chk("wb_wr", 32'(o_WriteReg), 32'(exp_wr));
        chk("wb_rd", o_ReadDataReg, exp_rd);
        chk("wb_alu", o_ALUOutReg, exp_alu);
        chk("wb_err", 32'(o_MemErr), 32'(exp_err));
        chk("wb_req", 32'(o_MemReq), 32'd0);
        chk("wb_we", 32'(o_MemWe), 32'd0);
        chk("wb_ready", 32'(o_ExReady), 32'd0);
        @(negedge clk);
        MemAck = 1'b0;
        chk("post_ready", 32'(o_ExReady), 32'd1);
        chk("post_rw", 32'(o_RegWrite), 32'd0);
        chk("post_m2r", 32'(o_MemtoReg), 32'(exp_m2r));
        chk("post_wr", 32'(o_WriteReg), 32'(exp_wr));
        chk("post_err", 32'(o_MemErr), 32'(exp_err));
    endtask

    initial begin
        reset = 1'b1; ExValid = 0; MemRead = 0; MemWrite = 0; RegWriteIn = 0;
        WriteRegIn = '0; ALUOut = '0; StoreData = '0; MemAck = 0; MemRData = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // ALU op, load with 3-cycle wait, store with immediate ack.
        do_op(0, 0, 1, 5'd9, 32'h0000_1234, 32'h0, 0, 32'h0, 0);
        do_op(1, 0, 1, 5'd4, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, 0);
        do_op(0, 1, 1, 5'd7, 32'h0000_0200, 32'hCAFE_0001, 1, 32'h0, 0);
        // Ack on the last allowed cycle wins over the timeout.
        do_op(1, 0, 1, 5'd3, 32'h0000_0300, 32'h0, TO, 32'h1357_9BDF, 0);
        // Timeout, then MemErr must stay set through a good op.
        do_op(1, 0, 1, 5'd5, 32'h0000_0400, 32'h0, 0, 32'h0, 0);
        do_op(0, 0, 1, 5'd6, 32'h0000_0055, 32'h0, 0, 32'h0, 0);
        // Illegal op and back-to-back ops with ExValid held high.
        do_op(1, 1, 1, 5'd8, 32'h0000_0500, 32'h0, 0, 32'h0, 1);
        do_op(1, 0, 1, 5'd10, 32'h0000_0600, 32'h0, 2, 32'h2468_ACE0, 1);
        do_op(0, 0, 1, 5'd11, 32'h0000_0077, 32'h0, 0, 32'h0, 1);
        ExValid = 1'b0;

        // Reset during the second MEM cycle discards the load.
        ExValid = 1'b1; MemRead = 1; MemWrite = 0; RegWriteIn = 1;
        WriteRegIn = 5'd12; ALUOut = 32'h700; StoreData = '0; MemAck = 0;
        @(negedge clk);
        ExValid = 1'b0;
        chk("rmid_req1", 32'(o_MemReq), 32'd1);
        @(negedge clk);
        chk("rmid_req2", 32'(o_MemReq), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("rmid");
        exp_err = 0; exp_m2r = 0; exp_wr = '0; exp_rd = '0; exp_alu = '0;
        @(negedge clk);
        chk("rmid_rw_after", 32'(o_RegWrite), 32'd0);
        chk("rmid_ready_after", 32'(o_ExReady), 32'd1);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic mr, mw;
            kind = $urandom_range(0, 9);
            mr = (kind >= 3 && kind <= 5) || kind == 9;
            mw = (kind >= 6 && kind <= 8) || kind == 9;
            do_op(mr, mw, 1'($urandom), 5'($urandom), $urandom, $urandom,
                  $urandom_range(1, TO + 2), $urandom, bit'($urandom_range(0, 1)));
            ExValid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
